fphub_adder_seq: RTL and testbench
==================================

Name:
fphub_adder_seq

Overview:
- Multi-cycle, parametrised HUB floating-point adder/subtractor with a start/ready and finish/ack handshake.
- Successor to the combinational HUB adder. Adds a registered datapath, a runtime add/subtract select, configurable guard bits, full LZD normalisation, and overflow/underflow handling.
- Sits between operand issue logic and the result consumer in the FPHUB arithmetic unit.

Parameters:
- M, 23, fraction width (stored mantissa bits).
- E, 8, exponent width; bias = 2^(E-1)-1.
- GUARD, 1, extra alignment bits below the ILSB; internal significand width W = M+2+GUARD, plus 1 carry bit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operand valid; accepted only when ready=1.
- ready  out  1  block idle and able to accept operands.
- op  in  1  0 = X+Y, 1 = X-Y (Y sign inverted); sampled with start.
- X  in  E+M+1  operand {sign, exp, frac}.
- Y  in  E+M+1  operand {sign, exp, frac}.
- finish  out  1  Z valid; held until ack.
- ack  in  1  consumer takes Z.
- Z  out  E+M+1  result.

Behaviour:
- One clock; reset is synchronous and active-high.
- HUB encoding:
  - value = (-1)^S * 2^(exp-bias) * 1.F1 (binary), where F1 means the fraction followed by an implicit ILSB = 1.
  - exp == 0 is zero (fraction ignored).
  - exp == all-ones is infinity of sign S (fraction ignored).
- Reset values: ready=1, finish=0, Z=0; state IDLE.
- State IDLE:
  - ready=1.
  - On start, register X, Y and op, then go to ALIGN. Y's sign is flipped if op=1.
- State ALIGN:
  - Classify special cases.
  - Compare exponents; on equal exponents compare fractions to pick the major operand.
  - Swap so the major operand is first.
  - Build significands {1, F, 1, GUARD zeros}.
  - Right-shift the minor by the exponent difference d; shifted-out bits are discarded.
  - If d >= W, the minor becomes 0.
  - Go to ADD.
- State ADD:
  - Effective subtraction = sign XOR.
  - Compute major ± minor in W+1 bits; the result is never negative after the swap.
  - Result sign = major sign.
  - Go to NORM.
- State NORM:
  - Carry set: shift right 1, exp+1.
  - Otherwise: LZD over the W bits, shift left by the leading-zero count, exp minus that count.
  - Result fraction = the M bits directly below the leading 1. Remaining bits are truncated; this truncation is HUB round-to-nearest.
  - Go to DONE.
- State DONE:
  - finish=1, Z stable.
  - On ack, go to IDLE with finish=0.
  - start is ignored while not IDLE; ready=0 in ALIGN, ADD, NORM and DONE.
- Latency: start accepted at cycle 0; finish=1 from cycle 4. The latency is fixed and identical for special cases.
- Special-case priority (resolved in ALIGN, carried to DONE):
  1. inf + opposite-sign inf gives NaN = {0, all-ones, all-ones}.
  2. Any other inf gives that inf with sign preserved and fraction 0.
  3. Both operands zero gives +0.
  4. A single zero operand gives the other operand unchanged (with op sign applied).
- Exact cancellation (zero magnitude after ADD) gives +0 (all bits 0).
- Overflow: normalised exp >= all-ones gives inf of the result sign, fraction 0.
- Underflow: normalised exp <= 0 gives +0.
- ack while finish=0 is ignored.
- ack and start both high in DONE: the block returns to IDLE; the new start is accepted on the next cycle, when ready=1.
- rst at any state: immediate abort, reset values on the next cycle, in-flight result discarded.

Test Plan (M=4, E=4, GUARD=1, bias 7):
1. X=9'h070, Y=9'h070, op=0 -> Z=9'h080 at cycle 4, finish held until ack.
2. X=9'h070, Y=9'h060, op=1 -> Z=9'h060 (alignment plus 1-bit LZD left shift). Also X=9'h070, Y=9'h170, op=0 -> Z=9'h000 (exact cancellation).
3. Specials:
   - X=9'h0F0, Y=9'h070 -> Z=9'h0F0.
   - X=9'h0F0, Y=9'h1F0 -> Z=9'h0FF.
   - X=9'h000, Y=9'h135 -> Z=9'h135.
   - X=9'h000, Y=9'h000 -> Z=9'h000.
4. Overflow X=9'h0EF, Y=9'h0EF -> Z=9'h0F0. Underflow X=9'h010, Y=9'h100 (zero) -> Z=9'h010; X=9'h018, Y=9'h110, op=0 -> Z=9'h000.
5. Handshake:
   - start pulsed while busy is ignored.
   - ack held low 10 cycles: Z stable, finish=1.
   - ack and start together in DONE: second operation accepted one cycle later.
   - Back-to-back throughput = one result per 5 cycles.
6. Assert rst during ADD -> next cycle ready=1, finish=0, Z=0; a subsequent operation completes correctly.

Source files
------------

// File: rtl/fphub_adder_seq_if.sv
// Operand/result handshake bundle for the sequential HUB adder.
// The issue side (master) drives start/op/X/Y and ack. The adder (slave) returns ready/finish/Z.
interface fphub_adder_seq_if #(
  parameter int M = 23,
  parameter int E = 8
);
  logic         start;
  logic         ready;
  logic         op;
  logic [E+M:0] X;
  logic [E+M:0] Y;
  logic         finish;
  logic         ack;
  logic [E+M:0] Z;

  modport master (output start, op, X, Y, ack, input ready, finish, Z);
  modport slave  (input start, op, X, Y, ack, output ready, finish, Z);
endinterface

// File: rtl/fphub_adder_seq.sv
// Multi-cycle HUB floating-point adder/subtractor.
// The FSM walks IDLE -> ALIGN -> ADD -> NORM -> DONE, with one register stage per state.
// Special operands are resolved in ALIGN and ride along, so the latency never changes.
module fphub_adder_seq #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int GUARD = 1
) (
  input  logic               clk,
  input  logic               rst,
  fphub_adder_seq_if.slave   bus
);
  localparam int N  = E + M + 1;
  localparam int W  = M + 2 + GUARD;
  localparam int LW = $clog2(W);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [N-1:0]   r_x, r_y, r_z, r_spec_z;
  logic           r_spec, r_sign, r_sub;
  logic [W-1:0]   r_maj, r_min;
  logic [W:0]     r_sum;
  logic [E-1:0]   r_exp;

  // Operand fields. r_y already carries the op-adjusted sign.
  logic         w_xs, w_ys, w_xz, w_yz, w_xi, w_yi, w_x_major, w_maj_s;
  logic [E-1:0] w_xe, w_ye, w_maj_e, w_min_e, w_d;
  logic [M-1:0] w_xf, w_yf, w_maj_f, w_min_f;
  logic [W-1:0] w_maj_sig, w_min_base, w_min_sig;

  assign w_xs = r_x[N-1];
  assign w_ys = r_y[N-1];
  assign w_xe = r_x[N-2 -: E];
  assign w_ye = r_y[N-2 -: E];
  assign w_xf = r_x[M-1:0];
  assign w_yf = r_y[M-1:0];
  assign w_xz = (w_xe == '0);
  assign w_yz = (w_ye == '0);
  assign w_xi = &w_xe;
  assign w_yi = &w_ye;

  // Order by magnitude so the subtraction in ADD can never go negative.
  assign w_x_major  = (w_xe > w_ye) || ((w_xe == w_ye) && (w_xf >= w_yf));
  assign w_maj_e    = w_x_major ? w_xe : w_ye;
  assign w_min_e    = w_x_major ? w_ye : w_xe;
  assign w_maj_f    = w_x_major ? w_xf : w_yf;
  assign w_min_f    = w_x_major ? w_yf : w_xf;
  assign w_maj_s    = w_x_major ? w_xs : w_ys;
  assign w_d        = w_maj_e - w_min_e;
  // Significand layout: hidden 1, fraction, ILSB = 1, then the guard zeros.
  assign w_maj_sig  = W'({1'b1, w_maj_f, 1'b1}) << GUARD;
  assign w_min_base = W'({1'b1, w_min_f, 1'b1}) << GUARD;
  assign w_min_sig  = (int'(w_d) >= W) ? '0 : (w_min_base >> w_d);

  logic         w_spec;
  logic [N-1:0] w_spec_z;
  // Special-case classification in priority order. An inf result has its fraction cleared.
  always_comb begin
    w_spec   = 1'b1;
    w_spec_z = '0;
    if (w_xi && w_yi && (w_xs != w_ys)) w_spec_z = {1'b0, {E{1'b1}}, {M{1'b1}}};
    else if (w_xi)                      w_spec_z = {w_xs, {E{1'b1}}, {M{1'b0}}};
    else if (w_yi)                      w_spec_z = {w_ys, {E{1'b1}}, {M{1'b0}}};
    else if (w_xz && w_yz)              w_spec_z = '0;
    else if (w_xz)                      w_spec_z = r_y;
    else if (w_yz)                      w_spec_z = r_x;
    else                                w_spec   = 1'b0;
  end

  logic [LW-1:0] w_lzc;
  logic [W-1:0]  w_norm;
  logic [E+1:0]  w_exp_n;
  logic [M-1:0]  w_frac;
  logic          w_unf, w_ovf;
  logic [N-1:0]  w_z;
  // Leading-zero count. Later iterations override earlier ones, so the highest set bit wins.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < W; i++)
      if (r_sum[i]) w_lzc = LW'(W - 1 - i);
  end

  assign w_norm  = r_sum[W-1:0] << w_lzc;
  // The top bit is a borrow indicator. Together with a zero value it marks underflow.
  assign w_exp_n = r_sum[W] ? ({2'b00, r_exp} + (E+2)'(1))
                            : ({2'b00, r_exp} - (E+2)'(w_lzc));
  assign w_unf   = w_exp_n[E+1] || (w_exp_n == '0);
  assign w_ovf   = w_exp_n[E] || (&w_exp_n[E-1:0]);
  // Keeping the M bits under the leading 1 and dropping the rest is the HUB rounding.
  assign w_frac  = r_sum[W] ? r_sum[W-1 -: M] : w_norm[W-2 -: M];

  // Result assembly: specials first, then cancellation, then exponent range.
  always_comb begin
    w_z = {r_sign, w_exp_n[E-1:0], w_frac};
    if (r_spec)              w_z = r_spec_z;
    else if (r_sum == '0)    w_z = '0;
    else if (w_unf)          w_z = '0;
    else if (w_ovf)          w_z = {r_sign, {E{1'b1}}, {M{1'b0}}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. start is only looked at in IDLE and ack only in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_DONE;
      S_DONE:  if (bus.ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers. Each state loads only its own stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0; r_y <= '0; r_z <= '0; r_spec_z <= '0;
      r_spec <= 1'b0; r_sign <= 1'b0; r_sub <= 1'b0;
      r_maj <= '0; r_min <= '0; r_sum <= '0; r_exp <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_x <= bus.X;
          r_y <= {bus.Y[N-1] ^ bus.op, bus.Y[N-2:0]};
        end
        S_ALIGN: begin
          r_maj    <= w_maj_sig;
          r_min    <= w_min_sig;
          r_exp    <= w_maj_e;
          r_sign   <= w_maj_s;
          r_sub    <= w_xs ^ w_ys;
          r_spec   <= w_spec;
          r_spec_z <= w_spec_z;
        end
        S_ADD:   r_sum <= r_sub ? ({1'b0, r_maj} - {1'b0, r_min})
                                : ({1'b0, r_maj} + {1'b0, r_min});
        S_NORM:  r_z <= w_z;
        default: ;
      endcase
    end
  end

  assign bus.ready  = (r_state == S_IDLE);
  assign bus.finish = (r_state == S_DONE);
  assign bus.Z      = r_z;
endmodule

// File: tb/tb_fphub_adder_seq.sv
// Directed and random bench for fphub_adder_seq with M=4, E=4, GUARD=1.
module tb_fphub_adder_seq;
  localparam int M = 4, E = 4, GUARD = 1;
  localparam int N = E + M + 1;
  localparam int W = M + 2 + GUARD;
  localparam int EMAX = (1 << E) - 1;

  logic clk = 1'b0;
  logic rst;
  int   npass = 0, nfail = 0, ntot = 0;

  fphub_adder_seq_if #(.M(M), .E(E)) bus();
  fphub_adder_seq #(.M(M), .E(E), .GUARD(GUARD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value-level model: integer significands are aligned, added, then renormalised.
  function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] yin, input logic o);
    logic [N-1:0] y, res;
    logic [E-1:0] eo;
    logic [M-1:0] fo;
    int xs, ys, xe, ye, xf, yf, as, ae, af, be, bf, a, b, r, p, en, fr;
    y = yin;
    if (o) y[N-1] = ~y[N-1];
    xs = int'(x[N-1]); ys = int'(y[N-1]);
    xe = int'(x[N-2:M]); ye = int'(y[N-2:M]);
    xf = int'(x[M-1:0]); yf = int'(y[M-1:0]);
    if (xe == EMAX && ye == EMAX && xs != ys) return {1'b0, {E{1'b1}}, {M{1'b1}}};
    if (xe == EMAX) return {x[N-1], {E{1'b1}}, {M{1'b0}}};
    if (ye == EMAX) return {y[N-1], {E{1'b1}}, {M{1'b0}}};
    if (xe == 0 && ye == 0) return '0;
    if (xe == 0) return y;
    if (ye == 0) return x;
    if (xe > ye || (xe == ye && xf >= yf)) begin
      as = xs; ae = xe; af = xf; be = ye; bf = yf;
    end else begin
      as = ys; ae = ye; af = yf; be = xe; bf = xf;
    end
    a = (((1 << M) + af) * 2 + 1) << GUARD;
    b = ((((1 << M) + bf) * 2 + 1) << GUARD) >> (ae - be);
    r = (xs == ys) ? a + b : a - b;
    if (r == 0) return '0;
    p = 0;
    for (int i = 0; i < 31; i++) if (((r >> i) & 1) == 1) p = i;
    en = ae + p - (W - 1);
    if (en <= 0) return '0;
    if (en >= EMAX) begin
      res = {1'b0, {E{1'b1}}, {M{1'b0}}};
      res[N-1] = as[0];
      return res;
    end
    fr = (p >= M) ? (r >> (p - M)) : (r << (M - p));
    eo = en[E-1:0];
    fo = fr[M-1:0];
    return {as[0], eo, fo};
  endfunction

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic o);
    int n;
    n = 0;
    while (!bus.ready && n < 20) begin @(posedge clk); #1; n++; end
    bus.X = x; bus.Y = y; bus.op = o; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts posedges from the acceptance edge (which counts as 1) until finish is seen.
  task automatic wait_finish(inout int lat);
    while (!bus.finish && lat < 30) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
  endtask

  task automatic op_check(input logic [N-1:0] x, input logic [N-1:0] y, input logic o,
                          input logic [N-1:0] ez, input string tag);
    int lat;
    issue(x, y, o);
    lat = 1;
    wait_finish(lat);
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".z"}, bus.Z, ez);
    ack_pulse();
    chk({tag, ".fin_off"}, bus.finish, 0);
  endtask

  logic [N-1:0] rx, ry;
  logic         rop;
  logic [E-1:0] re;
  logic [M-1:0] rf;
  logic [N-1:0] zhold;
  int lat, f0, f1, sel;
  logic stable, zok;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.ack = 1'b0; bus.op = 1'b0; bus.X = '0; bus.Y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", bus.ready, 1);
    chk("rst.finish", bus.finish, 0);
    chk("rst.z", bus.Z, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op_check(9'h070, 9'h070, 1'b0, 9'h080, "add_1p1");
    op_check(9'h070, 9'h060, 1'b1, 9'h060, "sub_align");
    op_check(9'h070, 9'h170, 1'b0, 9'h000, "cancel");
    op_check(9'h0F0, 9'h070, 1'b0, 9'h0F0, "inf_num");
    op_check(9'h0F0, 9'h1F0, 1'b0, 9'h0FF, "inf_nan");
    op_check(9'h000, 9'h135, 1'b0, 9'h135, "zero_y");
    op_check(9'h000, 9'h135, 1'b1, 9'h035, "zero_y_sub");
    op_check(9'h000, 9'h000, 1'b0, 9'h000, "zero_zero");
    op_check(9'h0EF, 9'h0EF, 1'b0, 9'h0F0, "overflow");
    op_check(9'h010, 9'h100, 1'b0, 9'h010, "x_zero_y");
    op_check(9'h018, 9'h110, 1'b0, 9'h000, "underflow");
    op_check(9'h0F0, 9'h0F0, 1'b1, 9'h0FF, "inf_sub_inf");

    // start while busy is ignored; ack withheld keeps the result parked
    issue(9'h070, 9'h070, 1'b0);
    bus.X = 9'h0F0; bus.Y = 9'h1F0; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("busy.ready", bus.ready, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    wait_finish(lat);
    chk("busy.lat", lat, 4);
    chk("busy.z", bus.Z, 9'h080);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Z !== 9'h080 || bus.finish !== 1'b1) stable = 1'b0;
    end
    chk("hold.stable", stable, 1);
    ack_pulse();
    repeat (6) @(posedge clk);
    #1;
    chk("busy.no_phantom", bus.finish, 0);
    chk("busy.idle", bus.ready, 1);

    // ack and start together in DONE
    issue(9'h070, 9'h060, 1'b1);
    lat = 1;
    wait_finish(lat);
    chk("ackst.z1", bus.Z, 9'h060);
    bus.X = 9'h070; bus.Y = 9'h070; bus.op = 1'b0; bus.ack = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk("ackst.ready", bus.ready, 1);
    chk("ackst.fin", bus.finish, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    wait_finish(lat);
    chk("ackst.lat", lat, 4);
    chk("ackst.z2", bus.Z, 9'h080);
    ack_pulse();

    // back-to-back throughput with start and ack held high
    bus.X = 9'h070; bus.Y = 9'h060; bus.op = 1'b1; bus.start = 1'b1; bus.ack = 1'b1;
    f0 = -1; f1 = -1; zok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.finish) begin
        if (bus.Z !== 9'h060) zok = 1'b0;
        if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
      end
    end
    bus.start = 1'b0;
    chk("b2b.first", f0, 3);
    chk("b2b.period", f1 - f0, 5);
    chk("b2b.z", zok, 1);
    repeat (6) @(posedge clk);
    #1;
    bus.ack = 1'b0;
    chk("b2b.drain", bus.ready, 1);

    // reset while in ADD
    zhold = bus.Z;
    chk("rstadd.pre_z", zhold, 9'h060);
    issue(9'h0EF, 9'h0EF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstadd.ready", bus.ready, 1);
    chk("rstadd.fin", bus.finish, 0);
    chk("rstadd.z", bus.Z, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rstadd.no_result", bus.finish, 0);
    op_check(9'h070, 9'h060, 1'b1, 9'h060, "post_rst");

    // random operands against the value-level model
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 2; j++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      re = '0;
        else if (sel == 1) re = '1;
        else               re = E'($urandom_range(1, EMAX - 1));
        rf = M'($urandom_range(0, (1 << M) - 1));
        if (j == 0) rx = {1'($urandom_range(0, 1)), re, rf};
        else        ry = {1'($urandom_range(0, 1)), re, rf};
      end
      rop = 1'($urandom_range(0, 1));
      op_check(rx, ry, rop, model(rx, ry, rop),
               $sformatf("rnd%0d_%0h_%0h_%0d", k, rx, ry, rop));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
